// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
//   Shared types and constants for the instruction fetch front end.
//   - fetch_entry_t : one buffered instruction with the address it came from
//   - NOP_INSTR     : canonical RV32I NOP (addi x0,x0,0)
//   - INSTR_BYTES   : fetch stride in bytes
//   - fetch_state_e : fetch FSM states
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Word address of a byte address (drops the two offset bits).
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Instruction buffer between the memory response path and the decoder.
//   DEPTH entries of fetch_entry_t; head is visible combinationally.
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     push_i/push_data_i  write one entry (accepted when not full, or full
//                    with a simultaneous pop)
//     pop_i          drop the head entry (ignored when empty)
//     flush_i        discard all entries; wins over push/pop
//     head_o         oldest entry
//     full_o, empty_o, count_o  occupancy status
// -----------------------------------------------------------------------------
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fetch_entry_t             push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_rptr;
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_count;

    logic            w_push;
    logic            w_pop;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign count_o = r_count;
    assign head_o  = r_mem[r_rptr];

    assign w_pop  = pop_i & ~empty_o;
    // A full buffer can still take a write when the head leaves this cycle.
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: nothing is read while the count is zero.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) r_mem[r_wptr] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Decoupled instruction fetch front end. Owns the fetch PC, issues word
//   reads to instruction memory under a credit limit, buffers returned words
//   with their PC and hands them to the decoder over valid/ready. A redirect
//   flushes buffered words and discards responses still in flight.
//   Parameters: RESET_PC (first fetch address), BUF_DEPTH (buffer entries and
//   max outstanding reads; power of two, >= 2).
//   Ports:
//     clk_i, rst_i                    clock, synchronous active-high reset
//     imem_req_o/addr_o/gnt_i         request channel (req&gnt = accepted)
//     imem_rvalid_i/rdata_i           in-order read responses
//     redirect_i/redirect_pc_i        flush and restart at a new PC
//     instr_valid_o/instr_o/pc_o      instruction to decoder
//     instr_ready_i                   decoder consumes (valid&ready = pop)
//     misalign_o                      only with IFETCH_MISALIGN_EN
//   Build option IFETCH_MISALIGN_EN: a redirect to a non word aligned PC
//   stops fetching and presents a NOP flagged misalign_o at that PC until it
//   is consumed or another redirect arrives. Without it, the low two bits of
//   the redirect PC are ignored.
// -----------------------------------------------------------------------------
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
`ifdef IFETCH_MISALIGN_EN
    output logic        misalign_o,
`endif
    input  logic        instr_ready_i
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e   r_state;
    fetch_state_e   w_state_nxt;

    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_resp_pc;
    logic [CW-1:0]  r_outst;
    logic [CW-1:0]  r_drop;

    logic [CW-1:0]  w_count;
    logic           w_empty;
    logic           w_full;
    fetch_entry_t   w_head;
    fetch_entry_t   w_push_data;

    logic           w_credit;
    logic           w_fetch_block;
    logic           w_hs;
    logic           w_rv;
    logic           w_rv_drop;
    logic           w_push;
    logic           w_fifo_pop;
    logic [CW-1:0]  w_outst_nxt;
    logic [31:0]    w_redir_pc;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_BOOT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // ---------------- request side ----------------
    // Every granted read owns a buffer slot until it is popped (or dropped),
    // so the buffer can never be asked to hold more than it has.
    assign w_credit   = ({1'b0, w_count} + {1'b0, r_outst}) < (CW+1)'(BUF_DEPTH);
    assign imem_req_o = (r_state == ST_RUN) & ~redirect_i & ~w_fetch_block & w_credit;
    assign imem_addr_o = r_fetch_pc;
    assign w_hs       = imem_req_o & imem_gnt_i;

    // ---------------- response side ----------------
    // A response with nothing outstanding is stray and ignored.
    assign w_rv        = imem_rvalid_i & (r_outst != '0);
    assign w_rv_drop   = w_rv & (r_drop != '0);
    assign w_push      = w_rv & ~w_rv_drop;
    assign w_outst_nxt = r_outst + CW'(w_hs) - CW'(w_rv);
    assign w_redir_pc  = word_align(redirect_pc_i);

    assign w_push_data.pc    = r_resp_pc;
    assign w_push_data.instr = imem_rdata_i;
    assign w_fifo_pop        = instr_ready_i & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (redirect_i) begin
                // Everything still in flight after this cycle belongs to the
                // old stream, including reads already marked for dropping.
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_drop     <= w_outst_nxt;
            end else begin
                if (w_hs)      r_fetch_pc <= r_fetch_pc + 32'(INSTR_BYTES);
                if (w_push)    r_resp_pc  <= r_resp_pc + 32'(INSTR_BYTES);
                if (w_rv_drop) r_drop     <= r_drop - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_fifo_pop),
        .flush_i     (redirect_i),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

    // ---------------- decoder side ----------------
`ifdef IFETCH_MISALIGN_EN
    logic        r_misalign;
    logic [31:0] r_mis_pc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
            r_mis_pc   <= '0;
        end else if (redirect_i) begin
            r_misalign <= |redirect_pc_i[1:0];
            r_mis_pc   <= redirect_pc_i;
        end else if (r_misalign && instr_ready_i) begin
            r_misalign <= 1'b0;
        end
    end

    assign w_fetch_block = r_misalign;
    assign misalign_o    = r_misalign;
    assign instr_valid_o = r_misalign | ~w_empty;
    assign instr_o       = r_misalign ? NOP_INSTR : (w_empty ? 32'h0 : w_head.instr);
    assign pc_o          = r_misalign ? r_mis_pc  : (w_empty ? 32'h0 : w_head.pc);
`else
    assign w_fetch_block = 1'b0;
    assign instr_valid_o = ~w_empty;
    // Outputs read as zero while idle rather than showing a stale slot.
    assign instr_o       = w_empty ? 32'h0 : w_head.instr;
    assign pc_o          = w_empty ? 32'h0 : w_head.pc;
`endif

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_rvalid_i && r_outst == '0));
            assert (!(w_push && w_full && !w_fifo_pop));
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch. A queue-based memory model answers
//   granted reads in order after a per-request latency. A stream model tracks
//   which PC the decoder must see next, how many current-stream words have
//   come back but not been consumed, and where the next fetch must go; the
//   request line is checked against the credit limit every cycle.
//   Build with IFETCH_MISALIGN_EN to also cover the misaligned-redirect path.
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import riscv_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
`ifdef IFETCH_MISALIGN_EN
    logic        misalign_o;
`endif

    always #5 clk_i = ~clk_i;

    instr_fetch #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
`ifdef IFETCH_MISALIGN_EN
        .misalign_o    (misalign_o),
`endif
        .instr_ready_i (instr_ready_i)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    mreq_t       memq[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc_n, epoch, ret_live, n_hs, n_pop;
    logic [31:0] exp_pc, fetch_exp, mis_pc, last_pop_pc;
    logic        mis;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
    endtask

    // Reset the DUT and the models; returns at a falling edge in cycle 0.
    task automatic do_reset();
        rst_i = 1'b1;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
        chk("rst_req",   32'(imem_req_o), 0);
        chk("rst_valid", 32'(instr_valid_o), 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc",    pc_o, 0);
        rst_i = 1'b0;
        memq.delete();
        cyc_n = 0; epoch = 0; ret_live = 0; n_hs = 0; n_pop = 0;
        exp_pc = RST_PC; fetch_exp = RST_PC; mis = 1'b0; mis_pc = '0;
    endtask

    // One clock cycle: drive, sample, check against the models, advance.
    task automatic cyc(input logic g, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input int lat);
        mreq_t e;
        logic  rv;
        logic  exp_req, exp_valid;
        int    outst;
        rv = 1'b0;
        e  = '{addr: 32'h0, due: 0, epoch: 0};
        if (memq.size() > 0 && memq[0].due <= cyc_n) begin
            e  = memq.pop_front();
            rv = 1'b1;
        end
        imem_gnt_i    = g;
        instr_ready_i = rdy;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        imem_rvalid_i = rv;
        imem_rdata_i  = rv ? mem_word(e.addr) : 32'hDEAD_BEEF;
        #2;
        s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o; s_pc = pc_o;

        outst     = memq.size() + (rv ? 1 : 0);
        exp_req   = (cyc_n >= 1) && !rd && !mis && (outst + ret_live < DEPTH);
        exp_valid = mis || (ret_live > 0);
        chk("imem_req_o", 32'(imem_req_o), 32'(exp_req));
        chk("instr_valid_o", 32'(instr_valid_o), 32'(exp_valid));
        if (exp_valid && instr_valid_o) begin
            if (mis) begin
                chk("mis_pc", pc_o, mis_pc);
                chk("mis_instr", instr_o, NOP_INSTR);
            end else begin
                chk("pc_o", pc_o, exp_pc);
                chk("instr_o", instr_o, mem_word(exp_pc));
            end
        end
        if (exp_req && imem_req_o) chk("imem_addr_o", imem_addr_o, fetch_exp);

        if (instr_valid_o && rdy) begin
            last_pop_pc = pc_o;
            n_pop++;
            if (mis) mis = 1'b0;
            else begin
                exp_pc += 4;
                if (ret_live > 0) ret_live--;
            end
        end
        if (rv && e.epoch == epoch) ret_live++;
        if (imem_req_o && g) begin
            memq.push_back('{addr: imem_addr_o, due: cyc_n + lat, epoch: epoch});
            fetch_exp += 4;
            n_hs++;
        end
        if (rd) begin
            epoch++;
            ret_live  = 0;
            exp_pc    = rpc & ~32'h3;
            fetch_exp = exp_pc;
            mis       = 1'b0;
`ifdef IFETCH_MISALIGN_EN
            if (rpc[1:0] != 2'b00) begin
                mis    = 1'b1;
                mis_pc = rpc;
            end
`endif
        end
        @(posedge clk_i);
        @(negedge clk_i);
        cyc_n++;
    endtask

    // Run ready=1 cycles until the decoder takes something, then check its PC.
    task automatic expect_next_pop(input string name, input logic [31:0] pc);
        int start;
        start = n_pop;
        last_pop_pc = 32'hFFFF_FFFF;
        for (int k = 0; k < 20 && n_pop == start; k++) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        chk(name, last_pop_pc, pc);
    endtask

    vec_t tbl[9];

    initial begin
        // gnt=1, 1-cycle memory, decoder always ready; gnt dropped in 6..7.
        tbl[0] = '{1, 1, 0, 32'h00, 0, 32'h0};
        tbl[1] = '{1, 1, 1, 32'h00, 0, 32'h0};
        tbl[2] = '{1, 1, 1, 32'h04, 0, 32'h0};
        tbl[3] = '{1, 1, 1, 32'h08, 1, 32'h0};
        tbl[4] = '{1, 1, 1, 32'h0C, 1, 32'h4};
        tbl[5] = '{1, 1, 1, 32'h10, 1, 32'h8};
        tbl[6] = '{0, 1, 1, 32'h14, 1, 32'hC};
        tbl[7] = '{0, 1, 1, 32'h14, 1, 32'h10};
        tbl[8] = '{1, 1, 1, 32'h14, 0, 32'h0};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].gnt, tbl[i].rdy, 1'b0, 32'h0, 1);
            chk("tbl_req", 32'(s_req), 32'(tbl[i].exp_req));
            chk("tbl_valid", 32'(s_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_req) chk("tbl_addr", s_addr, tbl[i].exp_addr);
            if (tbl[i].exp_valid || i == 0) chk("tbl_pc", s_pc, tbl[i].exp_pc);
        end
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Decoder stalled: exactly DEPTH reads, then the request drops.
        do_reset();
        repeat (10) cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
        chk("stall_reqs", 32'(n_hs), 32'(DEPTH));
        chk("stall_req_low", 32'(s_req), 0);
        repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);

        // Two reads in flight with slow memory, then redirect to 0x100.
        do_reset();
        repeat (3) cyc(1'b1, 1'b1, 1'b0, 32'h0, 3);
        chk("late_outstanding", 32'(memq.size()), 2);
        cyc(1'b1, 1'b1, 1'b1, 32'h100, 3);
        chk("redir_valid_low", 32'(instr_valid_o), 0);
        expect_next_pop("redir_first_pc", 32'h100);

        // Redirect in the same cycle as the pop of 0x8.
        do_reset();
        for (int k = 0; k < 20 && !(ret_live > 0 && exp_pc == 32'h8); k++)
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        cyc(1'b1, 1'b1, 1'b1, 32'h40, 1);
        chk("redir_pop_pc", last_pop_pc, 32'h8);
        expect_next_pop("redir_after_pop_pc", 32'h40);

        // Grant withheld for five cycles: address must hold.
        repeat (4) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1);
        begin
            logic [31:0] held;
            held = s_addr;
            repeat (4) begin
                cyc(1'b0, 1'b1, 1'b0, 32'h0, 1);
                chk("gnt_hold_addr", s_addr, held);
                chk("gnt_hold_req", 32'(s_req), 1);
            end
            cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
            chk("gnt_resume_addr", s_addr, held);
        end
        repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);

`ifdef IFETCH_MISALIGN_EN
        do_reset();
        repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'h0, 1);
        cyc(1'b1, 1'b0, 1'b1, 32'h102, 1);
        repeat (4) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
            chk("mis_flag", 32'(misalign_o), 1);
            chk("mis_pc_hold", s_pc, 32'h102);
            chk("mis_no_req", 32'(s_req), 0);
        end
        cyc(1'b1, 1'b0, 1'b1, 32'h200, 1);
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 1);
        chk("mis_cleared", 32'(misalign_o), 0);
        expect_next_pop("mis_resume_pc", 32'h200);
`endif

        // Randomized traffic with a reset in the middle.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic        g, r, rd;
            logic [31:0] rpc;
            if (i == 300) do_reset();
            g   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 24) == 0);
            rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
`ifndef IFETCH_MISALIGN_EN
            rpc[1:0] = 2'($urandom_range(0, 3));
`endif
            cyc(g, r, rd, rpc, $urandom_range(1, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
